// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage: PC, imem req/ack, 2-entry fetch buffer, redirect
// Optional misaligned-redirect trap enabled by defining MISALIGN_TRAP_EN.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP        = 32'h0000_0000,
  parameter int          WAIT_LIMIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_id_write,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ins_if,
  output logic [31:0] pc_4_if,
  output logic        if_flush,
  output logic        fetch_timeout,
  output logic        fetch_fault
);

  typedef enum logic [2:0] {
    BOOT, FETCH, HOLD, KILL
`ifdef MISALIGN_TRAP_EN
    , HALT
`endif
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, addr_q, target;
  logic [31:0] ins_q [2];
  logic [31:0] pc4_q [2];
  logic        head;
  logic [1:0]  count, cnt_nxt;
  logic [7:0]  wait_cnt;
  logic        push, pop, redirect, in_halt, halt_pend;

`ifdef MISALIGN_TRAP_EN
  logic misalign;
  assign target   = branch_target;
  assign misalign = branch_target[1:0] != 2'b00;
  assign in_halt  = state == HALT;
`else
  assign target   = {branch_target[31:2], branch_target[1:0] & 2'b00};
  assign in_halt  = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  // A redirect seen in HALT is ignored; only reset leaves HALT.
  assign redirect = branch_taken && !in_halt;
  assign if_flush = branch_taken;
  assign push     = imem_ack && state == FETCH && !redirect;
  assign pop      = if_id_write && count != 2'd0 && !redirect;
  assign cnt_nxt  = count + {1'b0, push} - {1'b0, pop};

  assign ins_if    = (count != 2'd0) ? ins_q[head] : NOP;
  assign pc_4_if   = (count != 2'd0) ? pc4_q[head] : pc + 32'd4;
  assign imem_addr = (state == KILL || in_halt) ? addr_q : pc;

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    case (state)
      BOOT:  state_nxt = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (redirect)                          state_nxt = imem_ack ? FETCH : KILL;
        else if (imem_ack && cnt_nxt == 2'd2)  state_nxt = HOLD;
      end
      HOLD:  if (redirect || cnt_nxt != 2'd2) state_nxt = FETCH;
      KILL: begin
        imem_req = 1'b1;
        if (imem_ack) state_nxt = FETCH;
      end
`ifdef MISALIGN_TRAP_EN
      HALT:  imem_req = halt_pend;
`endif
      default: state_nxt = BOOT;
    endcase
`ifdef MISALIGN_TRAP_EN
    if (redirect && misalign) state_nxt = HALT;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= BOOT;
      pc            <= RESET_PC;
      addr_q        <= RESET_PC;
      head          <= 1'b0;
      count         <= 2'd0;
      wait_cnt      <= 8'd0;
      fetch_timeout <= 1'b0;
      halt_pend     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == FETCH) addr_q <= pc;
      // Tracks whether a request is left open when HALT is entered.
      if (!in_halt)      halt_pend <= imem_req && !imem_ack;
      else if (imem_ack) halt_pend <= 1'b0;

      if (redirect) begin
        pc    <= target;
        head  <= 1'b0;
        count <= 2'd0;
      end else begin
        if (push) begin
          ins_q[head ^ count[0]] <= imem_rdata;
          pc4_q[head ^ count[0]] <= pc + 32'd4;
          pc <= pc + 32'd4;
        end
        if (pop) head <= ~head;
        count <= cnt_nxt;
      end

      if (imem_req && imem_ack) begin
        wait_cnt <= 8'd0;
      end else if (imem_req) begin
        if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
        if ({1'b0, wait_cnt} + 9'd1 >= 9'(WAIT_LIMIT)) fetch_timeout <= 1'b1;
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic fault_q;
  assign fetch_fault = fault_q;
  always_ff @(posedge clk) begin
    if (reset)                    fault_q <= 1'b0;
    else if (redirect && misalign) fault_q <= 1'b1;
  end
`endif

endmodule
